branch_resolve_unit: RTL and testbench

//  Execute-stage consumer of the integer ALU flag outputs (zero, sign, sltu).

---
 rtl/branch_resolve_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: turns ALU flags and funct3 into a registered
// redirect, holds the front end in flush for a fixed number of unstalled
// cycles, and keeps saturating branch/taken counters.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ex_valid,
  input  logic                 i_stall,
  input  logic                 i_branch,
  input  logic                 i_jump,
  input  logic                 i_jalr,
  input  logic [2:0]           i_funct3,
  input  logic                 i_zero_flag,
  input  logic                 i_sign_flag,
  input  logic                 i_sltu_flag,
  input  logic [31:0]          i_pc,
  input  logic [31:0]          i_imm,
  input  logic [31:0]          i_jalr_base,
  input  logic                 i_cnt_clr,
  output logic                 o_pc_sel,
  output logic [31:0]          o_target_pc,
  output logic                 o_flush,
  output logic                 o_illegal_br,
  output logic [CNT_WIDTH-1:0] o_branch_count,
  output logic [CNT_WIDTH-1:0] o_taken_count
);

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]        FLUSH_INIT = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0]        FLUSH_ONE  = CW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_FLUSHING
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;

  logic                 r_pc_sel;
  logic [31:0]          r_target_pc;
  logic                 r_illegal_br;
  logic [CNT_WIDTH-1:0] r_branch_count;
  logic [CNT_WIDTH-1:0] r_taken_count;

  logic        w_resolve;
  logic        w_illegal_f3;
  logic        w_cond;
  logic        w_cond_branch;
  logic        w_legal_br;
  logic        w_taken;
  logic [31:0] w_target;

  // The sign flag is only a debug tap; the compare results come from zero/sltu.
  logic w_unused_sign;
  assign w_unused_sign = i_sign_flag;

  assign w_resolve     = (r_state == S_IDLE) & i_ex_valid & ~i_stall & (i_branch | i_jump);
  assign w_illegal_f3  = (i_funct3[2:1] == 2'b01);
  assign w_cond_branch = w_resolve & i_branch & ~i_jump;
  assign w_legal_br    = w_cond_branch & ~w_illegal_f3;
  assign w_taken       = w_resolve & (i_jump | (i_branch & ~w_illegal_f3 & w_cond));
  assign w_target      = (i_jump & i_jalr) ? (i_jalr_base & ~32'h1) : (i_pc + i_imm);

  // Branch condition decode: BLT/BGE reuse the SLT result via the zero flag.
  always_comb begin
    w_cond = 1'b0;
    case (i_funct3)
      3'b000:  w_cond = i_zero_flag;
      3'b001:  w_cond = ~i_zero_flag;
      3'b100:  w_cond = ~i_zero_flag;
      3'b101:  w_cond = i_zero_flag;
      3'b110:  w_cond = i_sltu_flag;
      3'b111:  w_cond = ~i_sltu_flag;
      default: w_cond = 1'b0;
    endcase
  end

  // Flush FSM next state: count down unstalled cycles, freeze while stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_taken) begin
          w_state_nxt = S_FLUSHING;
          w_cnt_nxt   = FLUSH_INIT;
        end
      end
      S_FLUSHING: begin
        if (!i_stall) begin
          if (r_cnt <= FLUSH_ONE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - FLUSH_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Redirect pulse, held target address and illegal-funct3 pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_sel     <= 1'b0;
      r_target_pc  <= '0;
      r_illegal_br <= 1'b0;
    end else begin
      r_pc_sel     <= w_taken;
      r_illegal_br <= w_cond_branch & w_illegal_f3;
      if (w_taken) begin
        r_target_pc <= w_target;
      end
    end
  end

  // Saturating performance counters; a clear beats a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else if (i_cnt_clr) begin
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else begin
      if (w_legal_br && !(&r_branch_count)) begin
        r_branch_count <= r_branch_count + CNT_ONE;
      end
      if (w_legal_br && w_taken && !(&r_taken_count)) begin
        r_taken_count <= r_taken_count + CNT_ONE;
      end
    end
  end

  assign o_pc_sel       = r_pc_sel;
  assign o_target_pc    = r_target_pc;
  assign o_flush        = (r_state == S_FLUSHING);
  assign o_illegal_br   = r_illegal_br;
  assign o_branch_count = r_branch_count;
  assign o_taken_count  = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. A second narrow-counter instance
// sharing the same inputs reaches counter saturation in a few branches.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exValid, stall, branch, jump, jalr, zeroFlag, signFlag, sltuFlag, cntClr;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, jalrBase;

  logic        pcSel, flush, illegalBr;
  logic [31:0] targetPc, branchCount, takenCount;
  logic        satPcSel, satFlush, satIllegal;
  logic [31:0] satTarget;
  logic [1:0]  satBranchCount, satTakenCount;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_ex_valid(exValid), .i_stall(stall),
    .i_branch(branch), .i_jump(jump), .i_jalr(jalr), .i_funct3(funct3),
    .i_zero_flag(zeroFlag), .i_sign_flag(signFlag), .i_sltu_flag(sltuFlag),
    .i_pc(pc), .i_imm(imm), .i_jalr_base(jalrBase), .i_cnt_clr(cntClr),
    .o_pc_sel(pcSel), .o_target_pc(targetPc), .o_flush(flush),
    .o_illegal_br(illegalBr), .o_branch_count(branchCount), .o_taken_count(takenCount)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_WIDTH(2)) dutSat (
    .i_clk(clk), .i_rst_n(rstN), .i_ex_valid(exValid), .i_stall(stall),
    .i_branch(branch), .i_jump(jump), .i_jalr(jalr), .i_funct3(funct3),
    .i_zero_flag(zeroFlag), .i_sign_flag(signFlag), .i_sltu_flag(sltuFlag),
    .i_pc(pc), .i_imm(imm), .i_jalr_base(jalrBase), .i_cnt_clr(cntClr),
    .o_pc_sel(satPcSel), .o_target_pc(satTarget), .o_flush(satFlush),
    .o_illegal_br(satIllegal), .o_branch_count(satBranchCount), .o_taken_count(satTakenCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic jp, input logic jr, input logic [2:0] f3,
                               input logic z, input logic lt, input logic [31:0] p,
                               input logic [31:0] im, input logic [31:0] base);
    exValid  = 1'b1;
    branch   = br;
    jump     = jp;
    jalr     = jr;
    funct3   = f3;
    zeroFlag = z;
    sltuFlag = lt;
    signFlag = ~z;
    pc       = p;
    imm      = im;
    jalrBase = base;
  endtask

  task automatic clearInputs();
    exValid = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    jalr    = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; cntClr = 1'b0;
    clearInputs();
    funct3 = 3'b000; zeroFlag = 1'b0; signFlag = 1'b0; sltuFlag = 1'b0;
    pc = '0; imm = '0; jalrBase = '0;
    tick(); tick();
    checkOutput("rst_pc_sel", {31'b0, pcSel}, 32'h0);
    checkOutput("rst_flush", {31'b0, flush}, 32'h0);
    checkOutput("rst_target", targetPc, 32'h0);
    checkOutput("rst_illegal", {31'b0, illegalBr}, 32'h0);
    checkOutput("rst_bcount", branchCount, 32'h0);
    checkOutput("rst_tcount", takenCount, 32'h0);
    rstN = 1'b1;
    tick();

    // 1: taken BEQ
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0);
    tick(); clearInputs();
    checkOutput("beq_pc_sel", {31'b0, pcSel}, 32'h1);
    checkOutput("beq_target", targetPc, 32'h120);
    checkOutput("beq_flush1", {31'b0, flush}, 32'h1);
    checkOutput("beq_bcount", branchCount, 32'd1);
    checkOutput("beq_tcount", takenCount, 32'd1);
    tick();
    checkOutput("beq_pc_sel_drop", {31'b0, pcSel}, 32'h0);
    checkOutput("beq_flush2", {31'b0, flush}, 32'h1);
    checkOutput("beq_target_hold", targetPc, 32'h120);
    tick();
    checkOutput("beq_flush_end", {31'b0, flush}, 32'h0);

    // 2: not-taken BLTU
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0);
    tick(); clearInputs();
    checkOutput("bltu_pc_sel", {31'b0, pcSel}, 32'h0);
    checkOutput("bltu_flush", {31'b0, flush}, 32'h0);
    checkOutput("bltu_bcount", branchCount, 32'd2);
    checkOutput("bltu_tcount", takenCount, 32'd1);
    checkOutput("bltu_target_hold", targetPc, 32'h120);

    // 3: JALR, wrong-path branch during flush
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'h300, 32'h0, 32'h2003);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h300, 32'h4, 32'h0);
    checkOutput("jalr_pc_sel", {31'b0, pcSel}, 32'h1);
    checkOutput("jalr_target", targetPc, 32'h2002);
    checkOutput("jalr_flush1", {31'b0, flush}, 32'h1);
    checkOutput("jalr_bcount", branchCount, 32'd2);
    tick();
    checkOutput("jalr_wp_pc_sel", {31'b0, pcSel}, 32'h0);
    checkOutput("jalr_flush2", {31'b0, flush}, 32'h1);
    tick(); clearInputs();
    checkOutput("jalr_flush_end", {31'b0, flush}, 32'h0);
    checkOutput("jalr_wp_pc_sel2", {31'b0, pcSel}, 32'h0);
    checkOutput("jalr_wp_bcount", branchCount, 32'd2);
    checkOutput("jalr_wp_tcount", takenCount, 32'd1);

    // JAL with negative offset
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h1000, 32'hFFFF_FFF0, 32'h0);
    tick(); clearInputs();
    checkOutput("jal_target", targetPc, 32'h0FF0);
    checkOutput("jal_bcount", branchCount, 32'd2);
    tick(); tick();

    // 4: taken BNE with 3 stall cycles in flush, then reset mid-flush
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 32'h400, 32'h10, 32'h0);
    tick(); clearInputs();
    checkOutput("bne_target", targetPc, 32'h410);
    checkOutput("bne_flush_c1", {31'b0, flush}, 32'h1);
    checkOutput("bne_bcount", branchCount, 32'd3);
    checkOutput("bne_tcount", takenCount, 32'd2);
    stall = 1'b1;
    tick();
    checkOutput("bne_flush_c2", {31'b0, flush}, 32'h1);
    checkOutput("bne_stall_pc_sel", {31'b0, pcSel}, 32'h0);
    tick();
    checkOutput("bne_flush_c3", {31'b0, flush}, 32'h1);
    tick();
    checkOutput("bne_flush_c4", {31'b0, flush}, 32'h1);
    stall = 1'b0;
    tick();
    checkOutput("bne_flush_c5", {31'b0, flush}, 32'h1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_flush", {31'b0, flush}, 32'h0);
    checkOutput("midrst_pc_sel", {31'b0, pcSel}, 32'h0);
    checkOutput("midrst_target", targetPc, 32'h0);
    checkOutput("midrst_bcount", branchCount, 32'h0);
    checkOutput("midrst_tcount", takenCount, 32'h0);
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("postrst_flush", {31'b0, flush}, 32'h0);

    // 5: saturation on the 2-bit instance, then clear beats increment
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 32'h500, 32'h8, 32'h0);
      tick(); clearInputs();
      checkOutput("bge_target", targetPc, 32'h508);
      tick(); tick();
    end
    checkOutput("bge_bcount", branchCount, 32'd4);
    checkOutput("bge_tcount", takenCount, 32'd4);
    checkOutput("sat_bcount", {30'b0, satBranchCount}, 32'h3);
    checkOutput("sat_tcount", {30'b0, satTakenCount}, 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 32'h500, 32'h8, 32'h0);
    cntClr = 1'b1;
    tick(); clearInputs(); cntClr = 1'b0;
    checkOutput("clr_pc_sel", {31'b0, pcSel}, 32'h1);
    checkOutput("clr_bcount", branchCount, 32'h0);
    checkOutput("clr_tcount", takenCount, 32'h0);
    checkOutput("clr_sat_bcount", {30'b0, satBranchCount}, 32'h0);
    checkOutput("clr_sat_tcount", {30'b0, satTakenCount}, 32'h0);
    tick(); tick();

    // 6: illegal funct3 010 and 011
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h600, 32'h4, 32'h0);
    tick(); clearInputs();
    checkOutput("ill_pulse", {31'b0, illegalBr}, 32'h1);
    checkOutput("ill_pc_sel", {31'b0, pcSel}, 32'h0);
    checkOutput("ill_flush", {31'b0, flush}, 32'h0);
    checkOutput("ill_bcount", branchCount, 32'h0);
    tick();
    checkOutput("ill_pulse_end", {31'b0, illegalBr}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 32'h600, 32'h4, 32'h0);
    tick(); clearInputs();
    checkOutput("ill011_pulse", {31'b0, illegalBr}, 32'h1);
    checkOutput("ill011_tcount", takenCount, 32'h0);

    // Taken BLT with backward offset, then not-taken BGEU
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 32'h700, 32'hFFFF_FF00, 32'h0);
    tick(); clearInputs();
    checkOutput("blt_pc_sel", {31'b0, pcSel}, 32'h1);
    checkOutput("blt_target", targetPc, 32'h600);
    checkOutput("blt_tcount", takenCount, 32'd1);
    tick(); tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 32'h800, 32'h10, 32'h0);
    tick(); clearInputs();
    checkOutput("bgeu_pc_sel", {31'b0, pcSel}, 32'h0);
    checkOutput("bgeu_bcount", branchCount, 32'd2);
    checkOutput("bgeu_tcount", takenCount, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
